controlador_cronometro: RTL and testbench
=========================================

CONTROLADOR_CRONOMETRO -- requirements
Module: controlador_cronometro

Interface
REQ-001 Parameter: PRESCALE, default 4, clk cycles per count tick; legal range 1..255.
REQ-002 Port: clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-low reset (reset=0 resets immediately, independent of clk).
REQ-004 Port: start, input, 1, single-cycle command: begin/resume counting.
REQ-005 Port: stop, input, 1, single-cycle command: pause counting.
REQ-006 Port: clear, input, 1, single-cycle command: return to IDLE with value 00.
REQ-007 Port: load, input, 1, single-cycle command: preset digits from load_val.
REQ-008 Port: load_val, input, 8, BCD preset; [7:4] tens, [3:0] units.
REQ-009 Port: limit, input, 8, BCD terminal value; 8'h00 means free-run.
REQ-010 Port: units, output, 4, BCD units digit, registered.
REQ-011 Port: tens, output, 4, BCD tens digit, registered.
REQ-012 Port: running, output, 1, high exactly while state is RUN.
REQ-013 Port: tick, output, 1, one-cycle pulse in each cycle a count increment is applied.
REQ-014 Port: done, output, 1, one-cycle pulse on the cycle the terminal value is reached.
REQ-015 Port: load_err, output, 1, one-cycle pulse when a load is rejected for invalid BCD.

Function
REQ-016 States: IDLE, RUN, PAUSE, DONE; encoding is implementation choice.
REQ-017 Command priority, evaluated each cycle: clear > load > stop > start.
REQ-018 clear, any state: next state IDLE, digits 00, prescaler 0, no tick/done that cycle.
REQ-019 load in IDLE/PAUSE/DONE with both load_val digits <=9: digits <= load_val next cycle, prescaler 0, state unchanged except DONE -> IDLE.
REQ-020 load with any load_val digit >9: digits unchanged, load_err pulses next cycle.
REQ-021 load in RUN: ignored, no load_err.
REQ-022 stop in RUN: next state PAUSE; prescaler and digits hold; stop outside RUN ignored.
REQ-023 start in IDLE or PAUSE: next state RUN, counting resumes from current digits and prescaler value.
REQ-024 start in DONE: next state RUN, digits and prescaler reset to 0 first.
REQ-025 start and stop asserted together: stop rule applies; in non-RUN states neither acts.
REQ-026 In RUN the prescaler counts 0..PRESCALE-1; tick asserts combinationally-registered so the increment and tick occur on the cycle prescaler wraps to 0.
REQ-027 First tick occurs PRESCALE cycles after entering RUN with prescaler 0.
REQ-028 Increment: units 0..9 then wraps to 0 with carry; tens increments on carry; 99 -> 00.
REQ-029 Digits never hold a non-BCD value.
REQ-030 Terminal: if limit != 00 and the post-increment value equals limit, next state DONE and done pulses with that same update; digits hold limit.
REQ-031 limit == 00: no DONE; counter wraps 99 -> 00 indefinitely.
REQ-032 stop on a tick cycle: increment applies; if terminal reached, DONE wins over PAUSE.
REQ-033 limit changes mid-RUN take effect at the next tick compare; no retroactive DONE.

Reset
REQ-034 reset=0: state IDLE, units=0, tens=0, prescaler=0, running=0, tick=0, done=0, load_err=0, asynchronously.
REQ-035 Reset mid-RUN aborts counting immediately; after release the block stays IDLE until start.

Verification (PRESCALE=4)
REQ-036 Reset release, start, limit=8'h00 -> running=1 next cycle; tick every 4 cycles; units 0..9, tens increments; 99 wraps to 00 with no done.
REQ-037 limit=8'h12, start from 00 -> done pulse exactly when value becomes 12, running drops, digits hold 12; start again -> restarts from 00.
REQ-038 load_val=8'h47 in IDLE, start, stop after 2 ticks -> digits 49 held in PAUSE; start -> next tick after remaining prescaler cycles gives 50.
REQ-039 load_val=8'h3A -> load_err pulse, digits unchanged; load during RUN -> ignored, no load_err.
REQ-040 clear and start in same cycle during RUN -> IDLE, digits 00, running=0; reset=0 mid-RUN -> all outputs 0 before next clk edge.

Source files
------------

// File: rtl/controlador_cronometro.sv
// -----------------------------------------------------------------------------
// controlador_cronometro
// Two-digit BCD stopwatch controller. A prescaler divides clk by PRESCALE to
// produce count ticks. Each tick advances a 00..99 BCD counter. The counter can
// stop at a programmable terminal value or run freely and wrap.
//
// Parameters
//   PRESCALE  clk cycles per count tick (1..255)
//
// Ports
//   clk       system clock, rising-edge active
//   reset     asynchronous active-low reset
//   start     begin/resume counting (single-cycle command)
//   stop      pause counting (single-cycle command)
//   clear     return to IDLE with value 00 (single-cycle command)
//   load      preset digits from load_val (single-cycle command)
//   load_val  BCD preset, [7:4] tens, [3:0] units
//   limit     BCD terminal value, 8'h00 = free-run
//   units     BCD units digit (registered)
//   tens      BCD tens digit (registered)
//   running   high while in RUN
//   tick      one-cycle pulse with every applied increment
//   done      one-cycle pulse when the terminal value is reached
//   load_err  one-cycle pulse when a load is rejected as non-BCD
// -----------------------------------------------------------------------------
module controlador_cronometro #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic [7:0] limit,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic       running,
    output logic       tick,
    output logic       done,
    output logic       load_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

    // True when both nibbles are legal BCD digits.
    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] >= 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] >= 4'd9) begin
                r[7:4] = 4'd0;
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    state_t     r_state;
    logic [7:0] r_digits;
    logic [7:0] r_presc;
    logic       r_running;
    logic       r_tick;
    logic       r_done;
    logic       r_load_err;

    state_t     w_state_nxt;
    logic [7:0] w_digits_nxt;
    logic [7:0] w_presc_nxt;
    logic       w_tick_nxt;
    logic       w_done_nxt;
    logic       w_load_err_nxt;
    logic [7:0] w_digits_inc;
    logic       w_wrap;
    logic       w_terminal;

    assign w_digits_inc = bcd_inc(r_digits);
    assign w_wrap       = (r_presc >= PS_LAST);
    // Compared against the live limit, so a mid-run change applies at the next tick only.
    assign w_terminal   = (limit != 8'h00) && (w_digits_inc == limit);

    // Next-state and next-value logic; commands resolved as clear > load > stop > start.
    always_comb begin
        w_state_nxt    = r_state;
        w_digits_nxt   = r_digits;
        w_presc_nxt    = r_presc;
        w_tick_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;

        if (clear) begin
            w_state_nxt  = ST_IDLE;
            w_digits_nxt = 8'h00;
            w_presc_nxt  = 8'd0;
        end else if (load && (r_state != ST_RUN)) begin
            if (bcd_ok(load_val)) begin
                w_digits_nxt = load_val;
                w_presc_nxt  = 8'd0;
                if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (r_state == ST_RUN) begin
            // A load while running is ignored, so counting and stop still apply here.
            if (w_wrap) begin
                // Increment lands even if stop arrives on this cycle; DONE beats PAUSE.
                w_presc_nxt  = 8'd0;
                w_digits_nxt = w_digits_inc;
                w_tick_nxt   = 1'b1;
                if (w_terminal) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end else begin
                if (stop) begin
                    w_state_nxt = ST_PAUSE;
                end else begin
                    w_presc_nxt = r_presc + 8'd1;
                end
            end
        end else if (start && !stop) begin
            w_state_nxt = ST_RUN;
            if (r_state == ST_DONE) begin
                w_digits_nxt = 8'h00;
                w_presc_nxt  = 8'd0;
            end else begin
                w_digits_nxt = r_digits;
                w_presc_nxt  = r_presc;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, counter and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_digits   <= 8'h00;
            r_presc    <= 8'd0;
            r_running  <= 1'b0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_digits   <= w_digits_nxt;
            r_presc    <= w_presc_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_tick     <= w_tick_nxt;
            r_done     <= w_done_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign units    = r_digits[3:0];
    assign tens     = r_digits[7:4];
    assign running  = r_running;
    assign tick     = r_tick;
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_controlador_cronometro.sv
module tb_controlador_cronometro;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] limit;
    logic [3:0] units;
    logic [3:0] tens;
    logic       running;
    logic       tick;
    logic       done;
    logic       load_err;

    int n_cmp = 0;
    int n_err = 0;

    controlador_cronometro #(.PRESCALE(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .units    (units),
        .tens     (tens),
        .running  (running),
        .tick     (tick),
        .done     (done),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'((v / 10) % 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // flags order: {running, tick, done, load_err}
    task automatic chk_state(input string tag, input logic [7:0] exp_digits, input logic [3:0] exp_flags);
        chk({tag, "_digits"}, {tens, units}, exp_digits);
        chk({tag, "_flags"}, {4'h0, running, tick, done, load_err}, {4'h0, exp_flags});
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
        load_val = 8'h00; limit = 8'h00;
        step(); step();
        chk_state("reset", 8'h00, 4'b0000);
        reset = 1'b1;
        step();
        chk_state("post_reset_idle", 8'h00, 4'b0000);

        // Free-run: 100 ticks, wrap 99 -> 00 with no done
        start = 1'b1; step(); start = 1'b0;
        chk_state("free_start", 8'h00, 4'b1000);
        for (int k = 1; k <= 100; k++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                chk_state("free_wait", to_bcd(k - 1), 4'b1000);
            end
            step();
            chk_state("free_tick", to_bcd(k % 100), 4'b1100);
        end
        clear = 1'b1; step(); clear = 1'b0;
        chk_state("clear_after_free", 8'h00, 4'b0000);

        // Terminal value 12
        limit = 8'h12;
        start = 1'b1; step(); start = 1'b0;
        chk_state("lim_start", 8'h00, 4'b1000);
        for (int k = 1; k <= 12; k++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                chk_state("lim_wait", to_bcd(k - 1), 4'b1000);
            end
            step();
            if (k < 12) chk_state("lim_tick", to_bcd(k), 4'b1100);
            else        chk_state("lim_done", 8'h12, 4'b0110);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            chk_state("lim_hold", 8'h12, 4'b0000);
        end
        start = 1'b1; step(); start = 1'b0;
        chk_state("restart_from_done", 8'h00, 4'b1000);
        step(); step(); step(); step();
        chk_state("restart_tick", 8'h01, 4'b1100);
        clear = 1'b1; step(); clear = 1'b0;
        chk_state("clear2", 8'h00, 4'b0000);

        // Load 47, run two ticks, pause mid-prescale, resume
        limit = 8'h00;
        load_val = 8'h47; load = 1'b1; step(); load = 1'b0;
        chk_state("load47", 8'h47, 4'b0000);
        start = 1'b1; step(); start = 1'b0;
        chk_state("load_start", 8'h47, 4'b1000);
        step(); step(); step(); step();
        chk_state("tick48", 8'h48, 4'b1100);
        step(); step(); step(); step();
        chk_state("tick49", 8'h49, 4'b1100);
        step();
        chk_state("pre_stop", 8'h49, 4'b1000);
        stop = 1'b1; step(); stop = 1'b0;
        chk_state("paused", 8'h49, 4'b0000);
        step(); step(); step();
        chk_state("pause_hold", 8'h49, 4'b0000);
        start = 1'b1; step(); start = 1'b0;
        chk_state("resume", 8'h49, 4'b1000);
        step(); step();
        chk_state("resume_wait", 8'h49, 4'b1000);
        step();
        chk_state("resume_tick50", 8'h50, 4'b1100);

        // Limit set mid-run, stop on the terminal tick: DONE wins over PAUSE
        limit = 8'h51;
        step(); step(); step();
        chk_state("pre_term", 8'h50, 4'b1000);
        stop = 1'b1; step(); stop = 1'b0;
        chk_state("stop_on_term", 8'h51, 4'b0110);
        step();
        chk_state("done_hold", 8'h51, 4'b0000);

        // Invalid load rejected, valid load from DONE goes IDLE, load in RUN ignored
        load_val = 8'h3A; load = 1'b1; step(); load = 1'b0;
        chk_state("load_bad", 8'h51, 4'b0001);
        step();
        chk_state("load_err_clears", 8'h51, 4'b0000);
        load_val = 8'h20; load = 1'b1; step(); load = 1'b0;
        chk_state("load20_from_done", 8'h20, 4'b0000);
        limit = 8'h00;
        start = 1'b1; step(); start = 1'b0;
        chk_state("start20", 8'h20, 4'b1000);
        load_val = 8'h05; load = 1'b1; step(); load = 1'b0;
        chk_state("load_in_run", 8'h20, 4'b1000);
        step(); step();
        chk_state("run_after_load", 8'h20, 4'b1000);
        step();
        chk_state("tick21", 8'h21, 4'b1100);

        // clear + start together during RUN
        clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
        chk_state("clear_start", 8'h00, 4'b0000);
        start = 1'b1; step(); start = 1'b0;
        chk_state("start3", 8'h00, 4'b1000);
        step(); step(); step(); step();
        chk_state("tick01", 8'h01, 4'b1100);
        step();
        chk_state("pre_async_reset", 8'h01, 4'b1000);

        // Asynchronous reset mid-run, observed before any clock edge
        reset = 1'b0;
        #2;
        chk_state("async_reset", 8'h00, 4'b0000);
        #2;
        reset = 1'b1;
        step(); step(); step();
        chk_state("idle_after_reset", 8'h00, 4'b0000);

        // start and stop together outside RUN: neither acts
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk_state("start_stop_idle", 8'h00, 4'b0000);
        start = 1'b1; step(); start = 1'b0;
        chk_state("final_start", 8'h00, 4'b1000);
        step(); step(); step(); step();
        chk_state("final_tick", 8'h01, 4'b1100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
